// File: rtl/seq_div.sv
// Restoring 8-by-4 unsigned divider, one quotient bit per clock, start/done handshake.
// Optional macro SEQ_DIV_ZERO_DETECT_EN: short-circuit divide-by-zero and flag it on div_by_zero.
module seq_div (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] a,
  input  logic [3:0] b,
  output logic [7:0] q,
  output logic [3:0] r,
  output logic       busy,
  output logic       done,
  output logic       div_by_zero
);

  localparam int unsigned DW = 8;
  localparam int unsigned VW = 4;
  localparam int unsigned PW = VW + 1;
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] LAST_ITER = CW'(DW - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic [DW-1:0] r_dvd,  w_dvd_nxt;
  logic [VW-1:0] r_dvs,  w_dvs_nxt;
  logic [PW-1:0] r_p,    w_p_nxt;
  logic [DW-1:0] r_quo,  w_quo_nxt;
  logic [CW-1:0] r_cnt,  w_cnt_nxt;
  logic [DW-1:0] r_q,    w_q_nxt;
  logic [VW-1:0] r_r,    w_r_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_done, w_done_nxt;
`ifdef SEQ_DIV_ZERO_DETECT_EN
  logic          r_zero, w_zero_nxt;
  logic          r_dbz,  w_dbz_nxt;
`endif

  // One restoring step: shift in the dividend MSB, subtract the divisor if it fits.
  logic [PW-1:0] w_p_shift;
  logic [PW-1:0] w_p_sub;
  logic          w_fits;
  logic [PW-1:0] w_p_step;
  logic [DW-1:0] w_quo_step;

  assign w_p_shift  = {r_p[VW-1:0], r_dvd[DW-1]};
  assign w_fits     = (w_p_shift >= {1'b0, r_dvs});
  assign w_p_sub    = w_p_shift - {1'b0, r_dvs};
  assign w_p_step   = w_fits ? w_p_sub : w_p_shift;
  assign w_quo_step = {r_quo[DW-2:0], w_fits};

  always_comb begin
    w_state_nxt = r_state;
    w_dvd_nxt   = r_dvd;
    w_dvs_nxt   = r_dvs;
    w_p_nxt     = r_p;
    w_quo_nxt   = r_quo;
    w_cnt_nxt   = r_cnt;
    w_q_nxt     = r_q;
    w_r_nxt     = r_r;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
`ifdef SEQ_DIV_ZERO_DETECT_EN
    w_zero_nxt  = 1'b0;
    w_dbz_nxt   = 1'b0;
`endif
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt = S_RUN;
          w_dvd_nxt   = a;
          w_dvs_nxt   = b;
          w_p_nxt     = '0;
          w_quo_nxt   = '0;
          w_cnt_nxt   = '0;
`ifdef SEQ_DIV_ZERO_DETECT_EN
          // A zero divisor spends a single non-busy cycle before reporting.
          w_zero_nxt  = (b == '0);
          w_busy_nxt  = (b != '0);
`else
          w_busy_nxt  = 1'b1;
`endif
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
`ifdef SEQ_DIV_ZERO_DETECT_EN
        if (r_zero) begin
          w_state_nxt = S_DONE;
          w_q_nxt     = '1;
          w_r_nxt     = r_dvd[VW-1:0];
          w_done_nxt  = 1'b1;
          w_dbz_nxt   = 1'b1;
        end else begin
`else
        begin
`endif
          w_p_nxt   = w_p_step;
          w_quo_nxt = w_quo_step;
          w_dvd_nxt = {r_dvd[DW-2:0], 1'b0};
          if (r_cnt == LAST_ITER) begin
            w_state_nxt = S_DONE;
            w_q_nxt     = w_quo_step;
            w_r_nxt     = w_p_step[VW-1:0];
            w_done_nxt  = 1'b1;
          end else begin
            w_cnt_nxt  = r_cnt + CW'(1);
            w_busy_nxt = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_p     <= '0;
      r_quo   <= '0;
      r_cnt   <= '0;
      r_q     <= '0;
      r_r     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef SEQ_DIV_ZERO_DETECT_EN
      r_zero  <= 1'b0;
      r_dbz   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_dvd   <= w_dvd_nxt;
      r_dvs   <= w_dvs_nxt;
      r_p     <= w_p_nxt;
      r_quo   <= w_quo_nxt;
      r_cnt   <= w_cnt_nxt;
      r_q     <= w_q_nxt;
      r_r     <= w_r_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
`ifdef SEQ_DIV_ZERO_DETECT_EN
      r_zero  <= w_zero_nxt;
      r_dbz   <= w_dbz_nxt;
`endif
    end
  end

  assign q    = r_q;
  assign r    = r_r;
  assign busy = r_busy;
  assign done = r_done;
`ifdef SEQ_DIV_ZERO_DETECT_EN
  assign div_by_zero = r_dbz;
`else
  assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div: directed, randomized and exhaustive divisions vs. an arithmetic model.
module tb_seq_div;

  logic       clock;
  logic       reset_n;
  logic       start;
  logic [7:0] a;
  logic [3:0] b;
  logic [7:0] q;
  logic [3:0] r;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  int total = 0;
  int bad   = 0;
  int overlap_cnt = 0;

`ifdef SEQ_DIV_ZERO_DETECT_EN
  localparam bit ZD = 1'b1;
`else
  localparam bit ZD = 1'b0;
`endif

  seq_div dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .a           (a),
    .b           (b),
    .q           (q),
    .r           (r),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) if (busy && done) overlap_cnt++;

  // Reference: plain integer division, with the defined divide-by-zero result.
  function automatic void model(input int ma, input int mb, output int eq, output int er,
                                output int elat, output int edbz, output int ebusy);
    if (mb == 0) begin
      eq = 255; er = ma % 16;
      elat = ZD ? 1 : 8; edbz = ZD ? 1 : 0; ebusy = ZD ? 0 : 1;
    end else begin
      eq = ma / mb; er = ma % mb; elat = 8; edbz = 0; ebusy = 1;
    end
  endfunction

  // Issue one division and report what the DUT produced (lat = 0 means no done seen).
  task automatic do_div(input logic [7:0] ta, input logic [3:0] tb_, output int oq, output int orr,
                        output int odbz, output int lat, output int obusy);
    @(negedge clock);
    start = 1'b1; a = ta; b = tb_;
    @(negedge clock);
    start = 1'b0; a = 8'($urandom); b = 4'($urandom);
    obusy = int'(busy);
    lat = 0; oq = -1; orr = -1; odbz = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      if (done) begin
        lat = k; oq = int'(q); orr = int'(r); odbz = int'(div_by_zero);
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; start = 1'b1; a = 8'd200; b = 4'd7;
    repeat (2) @(negedge clock);
    total++;
    if (q !== 8'd0 || r !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0) begin
      bad++;
      $display("FAIL reset_vals: q=%0d r=%0d busy=%b done=%b dbz=%b required all zero", q, r, busy, done, div_by_zero);
    end
    reset_n = 1'b1; start = 1'b0;
    repeat (2) @(negedge clock);
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || q !== 8'd0) begin
      bad++;
      $display("FAIL reset_idle: busy=%b done=%b q=%0d required 0 0 0", busy, done, q);
    end
  endtask

  task automatic test_directed;
    int ta [5] = '{200, 255, 13, 0, 8'hA5};
    int tbv[5] = '{7, 1, 15, 5, 0};
    int oq, orr, odbz, lat, obusy, eq, er, elat, edbz, ebusy;
    for (int i = 0; i < 5; i++) begin
      do_div(8'(ta[i]), 4'(tbv[i]), oq, orr, odbz, lat, obusy);
      model(ta[i], tbv[i], eq, er, elat, edbz, ebusy);
      total++;
      if (oq !== eq || orr !== er) begin
        bad++;
        $display("FAIL directed_qr %0d/%0d: got q=%0d r=%0d required q=%0d r=%0d", ta[i], tbv[i], oq, orr, eq, er);
      end
      total++;
      if (lat !== elat) begin
        bad++;
        $display("FAIL directed_latency %0d/%0d: got %0d required %0d", ta[i], tbv[i], lat, elat);
      end
      total++;
      if (odbz !== edbz || obusy !== ebusy) begin
        bad++;
        $display("FAIL directed_flags %0d/%0d: dbz=%0d busy=%0d required dbz=%0d busy=%0d",
                 ta[i], tbv[i], odbz, obusy, edbz, ebusy);
      end
    end
  endtask

  task automatic test_protocol_abuse;
    int lat;
    int oq, orr;
    @(negedge clock);
    start = 1'b1; a = 8'd100; b = 4'd9;
    @(negedge clock);
    start = 1'b0;
    lat = 0; oq = -1; orr = -1;
    for (int k = 1; k <= 20; k++) begin
      if (k >= 2 && k <= 4) begin
        start = 1'b1; a = 8'($urandom); b = 4'($urandom_range(15, 1));
      end else begin
        start = 1'b0;
      end
      @(negedge clock);
      if (done) begin lat = k; oq = int'(q); orr = int'(r); break; end
    end
    start = 1'b0;
    total++;
    if (oq !== 11 || orr !== 1 || lat !== 8) begin
      bad++;
      $display("FAIL abuse_100_9: got q=%0d r=%0d lat=%0d required q=11 r=1 lat=8", oq, orr, lat);
    end
    repeat (3) @(negedge clock);
  endtask

  task automatic test_back_to_back;
    int dones[$];
    int bad_res = 0;
    @(negedge clock);
    start = 1'b1; a = 8'd200; b = 4'd7;
    for (int k = 0; k < 30; k++) begin
      @(negedge clock);
      if (done) begin
        dones.push_back(k);
        if (q !== 8'd28 || r !== 4'd4) bad_res++;
      end
    end
    start = 1'b0;
    total++;
    if (dones.size() < 3 || dones[1] - dones[0] != 9 || dones[2] - dones[1] != 9) begin
      bad++;
      $display("FAIL b2b_period: done count=%0d first gaps=%0d,%0d required >=3 dones with gap 9",
               dones.size(), dones.size() > 1 ? dones[1] - dones[0] : -1,
               dones.size() > 2 ? dones[2] - dones[1] : -1);
    end
    total++;
    if (bad_res != 0) begin
      bad++;
      $display("FAIL b2b_result: %0d dones with wrong q/r, required q=28 r=4 each", bad_res);
    end
    repeat (12) @(negedge clock);
  endtask

  task automatic test_reset_mid_run;
    int seen_done = 0;
    int oq, orr, odbz, lat, obusy;
    @(negedge clock);
    start = 1'b1; a = 8'd77; b = 4'd3;
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    total++;
    if (q !== 8'd0 || r !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL midrun_reset_vals: q=%0d r=%0d busy=%b done=%b required all zero", q, r, busy, done);
    end
    @(negedge clock);
    reset_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (done) seen_done++;
    end
    total++;
    if (seen_done != 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL midrun_abort: done pulses=%0d busy=%b required 0 0", seen_done, busy);
    end
    do_div(8'd77, 4'd3, oq, orr, odbz, lat, obusy);
    total++;
    if (oq !== 25 || orr !== 2 || lat !== 8) begin
      bad++;
      $display("FAIL midrun_rerun: got q=%0d r=%0d lat=%0d required q=25 r=2 lat=8", oq, orr, lat);
    end
  endtask

  task automatic test_mult_roundtrip;
    int oq, orr, odbz, lat, obusy;
    for (int x = 1; x <= 15; x++) begin
      for (int y = 1; y <= 15; y++) begin
        do_div(8'(x * y), 4'(y), oq, orr, odbz, lat, obusy);
        total++;
        if (oq !== x || orr !== 0 || lat !== 8) begin
          bad++;
          $display("FAIL roundtrip %0d*%0d/%0d: got q=%0d r=%0d lat=%0d required q=%0d r=0 lat=8",
                   x, y, y, oq, orr, lat, x);
        end
      end
    end
  endtask

  task automatic test_random;
    int oq, orr, odbz, lat, obusy, eq, er, elat, edbz, ebusy;
    int ra, rb;
    for (int i = 0; i < 60; i++) begin
      ra = int'($urandom_range(255, 0));
      rb = int'($urandom_range(15, 0));
      repeat ($urandom_range(2, 0)) @(negedge clock);
      do_div(8'(ra), 4'(rb), oq, orr, odbz, lat, obusy);
      model(ra, rb, eq, er, elat, edbz, ebusy);
      total++;
      if (oq !== eq || orr !== er || lat !== elat || odbz !== edbz || obusy !== ebusy) begin
        bad++;
        $display("FAIL random %0d/%0d: got q=%0d r=%0d lat=%0d dbz=%0d busy=%0d required q=%0d r=%0d lat=%0d dbz=%0d busy=%0d",
                 ra, rb, oq, orr, lat, odbz, obusy, eq, er, elat, edbz, ebusy);
      end
    end
  endtask

  task automatic test_exhaustive;
    int oq, orr, odbz, lat, obusy, eq, er, elat, edbz, ebusy;
    for (int x = 0; x < 256; x++) begin
      for (int y = 0; y < 16; y++) begin
        do_div(8'(x), 4'(y), oq, orr, odbz, lat, obusy);
        model(x, y, eq, er, elat, edbz, ebusy);
        total++;
        if (oq !== eq || orr !== er || lat !== elat || odbz !== edbz) begin
          bad++;
          $display("FAIL sweep %0d/%0d: got q=%0d r=%0d lat=%0d dbz=%0d required q=%0d r=%0d lat=%0d dbz=%0d",
                   x, y, oq, orr, lat, odbz, eq, er, elat, edbz);
        end
      end
    end
  endtask

  task automatic test_no_overlap;
    total++;
    if (overlap_cnt != 0) begin
      bad++;
      $display("FAIL busy_done_overlap: seen %0d cycles with both high, required 0", overlap_cnt);
    end
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; a = '0; b = '0;
    test_reset();
    test_directed();
    test_protocol_abuse();
    test_back_to_back();
    test_reset_mid_run();
    test_mult_roundtrip();
    test_random();
    test_exhaustive();
    test_no_overlap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
